conv_window_scan_ctrl: RTL and testbench

- Sequences a bank of K bidirectional window shift registers (one per window row, each K pixels long, B bits per pixel) so that a KxK convolution window scans a WxH image in serpentine order: left-to-right on even output rows, right-to-left on odd output rows.
- Fetches pixels from image memory through a single-outstanding read handshake and steers each pixel to its window row with a one-hot shift enable.
- Presents each fully populated window to the downstream MAC through a valid/ready handshake.

---
 rtl/conv_window_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_conv_window_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scan_ctrl.sv
// Serpentine KxK window scan controller: one pixel read in flight, each pixel steered to its window row by a one-hot shift enable.
// Enable pulse follows rd_valid by one cycle; win_valid holds with reads paused until win_ready.
module conv_window_scan_ctrl #(
  parameter int W  = 64,
  parameter int H  = 64,
  parameter int K  = 11,
  parameter int B  = 8,
  parameter int AW = 12,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_valid,
  input  logic [B-1:0]  rd_data,
  output logic [B-1:0]  sh_din,
  output logic [K-1:0]  sh_up_en,
  output logic [K-1:0]  sh_down_en,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y
);
  localparam int RW = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (W * H > 2 ** AW) begin : g_bad_aw
    $error("conv_window_scan_ctrl: W*H exceeds the 2**AW address space");
  end
  if (W < K || H < K) begin : g_bad_k
    $error("conv_window_scan_ctrl: image must be at least KxK");
  end

  logic [2:0]    state;
  logic [RW-1:0] row;
  logic [RW-1:0] col_cnt;
  logic [XW-1:0] col;
  logic          outst;
  logic          down;
  logic          accept;
  logic          last_row;
  logic          last_col;
  logic          more_x;
  logic          more_y;
  logic [AW-1:0] addr_row;

  // Even window rows scan left-to-right and shift down; odd rows the reverse.
  assign down     = ~win_y[0];
  assign accept   = rd_valid && outst && !rd_req;
  assign last_row = (row == RW'(K - 1));
  assign last_col = (state != S_PRIME) || (col_cnt == RW'(K - 1));
  assign more_x   = down ? (win_x < XW'(W - K)) : (win_x != '0);
  assign more_y   = (win_y < YW'(H - K));
  assign addr_row = AW'(win_y) + AW'(row);
  assign rd_addr  = rd_req ? (addr_row * AW'(W) + AW'(col)) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_req     <= 1'b0;
      sh_din     <= '0;
      sh_up_en   <= '0;
      sh_down_en <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      row        <= '0;
      col_cnt    <= '0;
      col        <= '0;
      outst      <= 1'b0;
    end else begin
      rd_req     <= 1'b0;
      sh_up_en   <= '0;
      sh_down_en <= '0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PRIME;
            busy    <= 1'b1;
            win_x   <= '0;
            win_y   <= '0;
            col     <= '0;
            col_cnt <= '0;
            row     <= '0;
            rd_req  <= 1'b1;
            outst   <= 1'b1;
          end
        end
        S_PRIME, S_STEP: begin
          if (accept) begin
            sh_din <= rd_data;
            if (down) sh_down_en <= K'(1) << row;
            else      sh_up_en   <= K'(1) << row;
            if (!last_row) begin
              row    <= row + 1'b1;
              rd_req <= 1'b1;
            end else if (!last_col) begin
              row     <= '0;
              col_cnt <= col_cnt + 1'b1;
              col     <= down ? col + 1'b1 : col - 1'b1;
              rd_req  <= 1'b1;
            end else begin
              row   <= '0;
              outst <= 1'b0;
              state <= S_WIN;
              if (state == S_STEP) win_x <= down ? win_x + 1'b1 : win_x - 1'b1;
            end
          end
        end
        S_WIN: begin
          if (!win_valid) begin
            win_valid <= 1'b1;
          end else if (win_ready) begin
            win_valid <= 1'b0;
            if (more_x) begin
              state  <= S_STEP;
              col    <= down ? win_x + XW'(K) : win_x - 1'b1;
              rd_req <= 1'b1;
              outst  <= 1'b1;
            end else if (more_y) begin
              // Next row has opposite parity, so its prime starts at the far edge.
              state   <= S_PRIME;
              win_y   <= win_y + 1'b1;
              col_cnt <= '0;
              col     <= down ? XW'(W - 1) : '0;
              win_x   <= down ? XW'(W - K) : '0;
              rd_req  <= 1'b1;
              outst   <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  a_en_exclusive: assert property (@(posedge clk) disable iff (!rstn)
    !((|sh_up_en) && (|sh_down_en)));
  a_en_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(sh_up_en | sh_down_en));

endmodule

// File: tb/tb_conv_window_scan_ctrl.sv
// Bench for conv_window_scan_ctrl: randomized read latency/backpressure against a serpentine-scan reference model.
module tb_conv_window_scan_ctrl;
  localparam int W = 5, H = 4, K = 3, B = 8, AW = 12;
  localparam int XW = $clog2(W), YW = $clog2(H);
  localparam int NWIN = (W - K + 1) * (H - K + 1);
  localparam int NRD  = (H - K + 1) * (K * K + (W - K) * K);

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, rd_valid = 1'b0, win_ready = 1'b0;
  logic [B-1:0] rd_data = '0;
  logic busy, done, rd_req, win_valid;
  logic [AW-1:0] rd_addr;
  logic [B-1:0] sh_din;
  logic [K-1:0] sh_up_en, sh_down_en;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;

  conv_window_scan_ctrl #(.W(W), .H(H), .K(K), .B(B), .AW(AW), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .sh_din(sh_din), .sh_up_en(sh_up_en), .sh_down_en(sh_down_en),
    .win_valid(win_valid), .win_ready(win_ready), .win_x(win_x), .win_y(win_y));

  always #5 clk = ~clk;

  typedef struct { int addr; int row; bit up; } rd_t;
  typedef struct { int x; int y; } win_t;

  int checks = 0, errors = 0, done_cnt = 0;
  bit rand_lat = 0, spur_en = 0, frame_act = 0, pinned = 0;
  rd_t rq[$];
  rd_t eq[$];
  win_t wq[$];
  int sw[K][K];
  int rd_seen, win_seen, outs, mism;
  bit prev_wv, prev_acc, last_en_prev, last_en_now;
  rd_t e_cur, r_cur;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected reads and windows for one frame, straight from the scan order.
  task automatic build_model();
    rd_t r;
    win_t w;
    int p0[9];
    int p1[9];
    int wx[6];
    int wy[6];
    rq.delete(); eq.delete(); wq.delete();
    for (int y = 0; y <= H - K; y++) begin
      bit odd = (y % 2) == 1;
      for (int c = 0; c < K; c++) begin
        int pc = odd ? W - 1 - c : c;
        for (int j = 0; j < K; j++) begin
          r.addr = (y + j) * W + pc; r.row = j; r.up = odd; rq.push_back(r);
        end
      end
      for (int s = 0; s <= W - K; s++) begin
        w.x = odd ? W - K - s : s; w.y = y; wq.push_back(w);
        if (s > 0) begin
          int sc = odd ? w.x : w.x + K - 1;
          for (int j = 0; j < K; j++) begin
            r.addr = (y + j) * W + sc; r.row = j; r.up = odd; rq.push_back(r);
          end
        end
      end
    end
    eq = rq;
    if (!pinned) begin
      pinned = 1;
      p0 = '{0, 5, 10, 1, 6, 11, 2, 7, 12};
      p1 = '{9, 14, 19, 8, 13, 18, 7, 12, 17};
      wx = '{0, 1, 2, 2, 1, 0};
      wy = '{0, 0, 0, 1, 1, 1};
      chk("model_read_total", rq.size(), 30);
      chk("model_window_total", wq.size(), 6);
      for (int k = 0; k < 9; k++) begin
        chk("model_prime0_addr", rq[k].addr, p0[k]);
        chk("model_prime1_addr", rq[15 + k].addr, p1[k]);
        chk("model_prime_rows", rq[k].row, k % 3);
      end
      chk("model_prime0_dir", rq[0].up, 0);
      chk("model_prime1_dir", rq[15].up, 1);
      for (int k = 0; k < 6; k++) begin
        chk("model_win_x", wq[k].x, wx[k]);
        chk("model_win_y", wq[k].y, wy[k]);
      end
    end
  endtask

  // Memory: data = low byte of address; latency 1 or random 1..7; optional idle noise.
  initial begin
    int a;
    int lat;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        a = int'(rd_addr);
        lat = rand_lat ? int'($urandom_range(1, 7)) : 1;
        repeat (lat) @(posedge clk);
        #1 rd_valid = 1'b1; rd_data = a[7:0];
        @(posedge clk);
        #1 rd_valid = 1'b0;
      end else if (spur_en && !busy && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 rd_valid = 1'b1; rd_data = 8'hEE;
        @(posedge clk);
        #1 rd_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("reset_outputs", {busy, done, rd_req, rd_addr, sh_din, sh_up_en, sh_down_en,
                            win_valid, win_x, win_y}, 0);
      rq.delete(); eq.delete(); wq.delete();
      frame_act = 0; outs = 0; prev_wv = 0; prev_acc = 0; last_en_prev = 0;
    end else begin
      last_en_now = 0;
      if (done) chk("busy_low_with_done", busy, 0);
      else chk("busy", busy, frame_act);
      if (sh_up_en != '0 || sh_down_en != '0) begin
        chk("enable_onehot", $countones(sh_up_en) + $countones(sh_down_en), 1);
        chk("enable_expected", eq.size() > 0, 1);
        if (eq.size() > 0) begin
          e_cur = eq.pop_front();
          chk("enable_row_dir", {sh_up_en, sh_down_en},
              e_cur.up ? (1 << (e_cur.row + K)) : (1 << e_cur.row));
          chk("sh_din", sh_din, e_cur.addr & 255);
          last_en_now = (e_cur.row == K - 1);
        end
        for (int j = 0; j < K; j++) begin
          if (sh_down_en[j]) begin
            for (int i = 0; i < K - 1; i++) sw[j][i] = sw[j][i + 1];
            sw[j][K - 1] = int'(sh_din);
          end
          if (sh_up_en[j]) begin
            for (int i = K - 1; i > 0; i--) sw[j][i] = sw[j][i - 1];
            sw[j][0] = int'(sh_din);
          end
        end
        outs--;
      end
      if (rd_req) begin
        chk("single_outstanding", outs, 0);
        chk("no_req_while_win_valid", win_valid, 0);
        chk("read_expected", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          r_cur = rq.pop_front();
          chk("rd_addr", rd_addr, r_cur.addr);
        end
        outs++;
        rd_seen++;
      end
      if (win_valid) begin
        if (!prev_wv) chk("win_valid_after_last_enable", last_en_prev, 1);
        chk("window_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          chk("win_x", win_x, wq[0].x);
          chk("win_y", win_y, wq[0].y);
          mism = 0;
          for (int j = 0; j < K; j++)
            for (int i = 0; i < K; i++)
              if (sw[j][i] != (((wq[0].y + j) * W + wq[0].x + i) & 255)) mism++;
          chk("window_bad_pixels", mism, 0);
          if (win_ready) begin
            void'(wq.pop_front());
            win_seen++;
          end
        end
      end
      if (done) begin
        chk("done_in_frame", frame_act, 1);
        chk("done_after_accept", prev_acc, 1);
        chk("reads_per_frame", rd_seen, NRD);
        chk("windows_per_frame", win_seen, NWIN);
        chk("reads_left", rq.size(), 0);
        chk("windows_left", wq.size(), 0);
        frame_act = 0;
        done_cnt++;
      end
      if (start && !busy && !done) begin
        build_model();
        frame_act = 1; rd_seen = 0; win_seen = 0; outs = 0;
      end
      prev_wv = win_valid;
      prev_acc = win_valid && win_ready;
      last_en_prev = last_en_now;
    end
  end

  // mode 0: ready=1; 1: random ready + 10-cycle stall at (1,0);
  // 2: extra start mid-scan and on the done cycle; 3: reset during STEP of (1,1).
  task automatic run_frame(input int mode);
    int d0, cyc, stall;
    bit fired;
    d0 = done_cnt; cyc = 0; stall = 0; fired = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (done_cnt == d0 && cyc < 4000 && !fired) begin
      case (mode)
        1: begin
          if (win_valid && win_x == 1 && win_y == 0 && stall < 10) begin
            win_ready = 1'b0; stall++;
          end else win_ready = ($urandom_range(0, 1) == 1);
        end
        2: begin
          win_ready = 1'b1;
          start = (cyc == 20 || done);
        end
        3: begin
          win_ready = 1'b1;
          if (win_valid && win_x == 2 && win_y == 1) begin
            repeat (3) @(posedge clk);
            #1 rstn = 1'b0;
            fired = 1;
          end
        end
        default: win_ready = 1'b1;
      endcase
      if (!fired) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    win_ready = 1'b1;
    if (cyc >= 4000) chk("frame_timeout", 1, 0);
    if (mode == 1) chk("stall_cycles", stall, 10);
    if (mode == 3) begin
      chk("reset_point_reached", fired, 1);
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      repeat (12) @(posedge clk);
    end else begin
      chk("done_pulses", done_cnt - d0, 1);
    end
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    win_ready = 1'b1;
    run_frame(0);
    run_frame(1);
    rand_lat = 1;
    spur_en = 1;
    repeat (30) @(posedge clk);
    spur_en = 0;
    repeat (12) @(posedge clk);
    run_frame(0);
    run_frame(2);
    repeat (5) @(negedge clk);
    chk("start_on_done_ignored", busy, 0);
    run_frame(0);
    run_frame(3);
    run_frame(0);
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
